// File: rtl/bf16_seq_adder.sv
// Multi-cycle bfloat16 adder with valid/ready request and response handshakes.
// One operation in flight; alignment and normalisation move one bit per cycle.
module bf16_seq_adder #(
    parameter int EW  = 8,
    parameter int MW  = 7,
    parameter int GRS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EW+MW:0]    a,
    input  logic [EW+MW:0]    b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EW+MW:0]    sum,
    output logic              ovf
);
    localparam int W  = 1 + EW + MW;
    localparam int SW = 1 + MW + GRS;
    localparam int XW = EW + 2;
    localparam int CW = $clog2(SW + 1);
    localparam logic [EW-1:0] EMAX = '1;
    localparam logic [W-1:0]  QNAN = {1'b0, EMAX, 1'b1, {(MW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic           ovf_q, ovf_d, sx_q, sx_d, sy_q, sy_d;
    logic [XW-1:0]  ex_q, ex_d;
    logic [SW-1:0]  mx_q, mx_d, my_q, my_d;
    logic [SW:0]    acc_q, acc_d;
    logic [EW-1:0]  d_q, d_d;
    logic [CW-1:0]  acnt_q, acnt_d;

    // Result significand rounded to nearest-even; top bit is the mantissa carry-out.
    function automatic logic [MW+1:0] round_rne(input logic [SW-1:0] sig);
        logic up;
        up = sig[GRS-1] & ((|sig[GRS-2:0]) | sig[GRS]);
        return {1'b0, sig[SW-1:GRS]} + {{(MW+1){1'b0}}, up};
    endfunction

    logic          sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap;
    logic [EW-1:0] ea, eb;
    logic [MW-1:0] ma, mb;
    logic [W-1:0]  xop, yop;
    logic [SW:0]   addres;
    logic [MW+1:0] rnd;
    logic [XW-1:0] exp_r;

    assign sa     = a_q[W-1];
    assign sb     = b_q[W-1];
    assign ea     = a_q[W-2:MW];
    assign eb     = b_q[W-2:MW];
    assign ma     = a_q[MW-1:0];
    assign mb     = b_q[MW-1:0];
    assign a_nan  = (ea == EMAX) && (ma != '0);
    assign b_nan  = (eb == EMAX) && (mb != '0);
    assign a_inf  = (ea == EMAX) && (ma == '0);
    assign b_inf  = (eb == EMAX) && (mb == '0);
    // Exponent zero covers both true zeros and subnormals, which are flushed.
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign swap   = a_q[W-2:0] < b_q[W-2:0];
    assign xop    = swap ? b_q : a_q;
    assign yop    = swap ? a_q : b_q;
    assign addres = (sx_q == sy_q) ? ({1'b0, mx_q} + {1'b0, my_q})
                                   : ({1'b0, mx_q} - {1'b0, my_q});
    assign rnd    = round_rne(acc_q[SW-1:0]);
    assign exp_r  = ex_q + {{(XW-1){1'b0}}, rnd[MW+1]};

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        ex_d    = ex_q;
        mx_d    = mx_q;
        my_d    = my_q;
        acc_d   = acc_q;
        d_d     = d_q;
        acnt_d  = acnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    ovf_d   = 1'b0;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                state_d = S_DONE;
                if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
                    sum_d = QNAN;
                else if (a_inf)
                    sum_d = a_q;
                else if (b_inf)
                    sum_d = b_q;
                else if (a_zero && b_zero)
                    sum_d = {sa & sb, {(W-1){1'b0}}};
                else if (a_zero)
                    sum_d = b_q;
                else if (b_zero)
                    sum_d = a_q;
                else begin
                    sx_d    = xop[W-1];
                    sy_d    = yop[W-1];
                    ex_d    = {{(XW-EW){1'b0}}, xop[W-2:MW]};
                    mx_d    = {1'b1, xop[MW-1:0], {GRS{1'b0}}};
                    my_d    = {1'b1, yop[MW-1:0], {GRS{1'b0}}};
                    d_d     = xop[W-2:MW] - yop[W-2:MW];
                    acnt_d  = '0;
                    state_d = (xop[W-2:MW] == yop[W-2:MW]) ? S_ADD : S_ALIGN;
                end
            end
            S_ALIGN: begin
                my_d   = {1'b0, my_q[SW-1:1]};
                my_d[0] = my_q[1] | my_q[0];
                d_d    = d_q - EW'(1);
                acnt_d = acnt_q + CW'(1);
                if ((d_q == EW'(1)) || (acnt_q == CW'(SW-1))) begin
                    // Any shift still owed once the window is exhausted only feeds sticky.
                    if (d_q != EW'(1))
                        my_d = {{(SW-1){1'b0}}, |my_q};
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                acc_d = addres;
                if (addres == '0) begin
                    sum_d   = '0;
                    state_d = S_DONE;
                end else if (addres[SW] || !addres[SW-1])
                    state_d = S_NORM;
                else
                    state_d = S_ROUND;
            end
            S_NORM: begin
                if (acc_q[SW]) begin
                    acc_d   = {1'b0, acc_q[SW:2], acc_q[1] | acc_q[0]};
                    ex_d    = ex_q + XW'(1);
                    state_d = S_ROUND;
                end else begin
                    acc_d = {acc_q[SW-1:0], 1'b0};
                    ex_d  = ex_q - XW'(1);
                    if (ex_q == XW'(1)) begin
                        sum_d   = {sx_q, {(W-1){1'b0}}};
                        state_d = S_DONE;
                    end else if (acc_q[SW-2])
                        state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = S_DONE;
                if (exp_r >= {{(XW-EW){1'b0}}, EMAX}) begin
                    sum_d = {sx_q, EMAX, {MW{1'b0}}};
                    ovf_d = 1'b1;
                end else
                    sum_d = {sx_q, exp_r[EW-1:0], rnd[MW+1] ? rnd[MW:1] : rnd[MW-1:0]};
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q    <= a_d;
        b_q    <= b_d;
        sx_q   <= sx_d;
        sy_q   <= sy_d;
        ex_q   <= ex_d;
        mx_q   <= mx_d;
        my_q   <= my_d;
        acc_q  <= acc_d;
        d_q    <= d_d;
        acnt_q <= acnt_d;
    end
endmodule
